// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus: per-requester valid/register/data with a one-hot ready back.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_reg;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, req_reg, req_data, input req_ready);
    modport slave  (input req_valid, req_reg, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single register-file write port and tracks pending writes.
// Define WB_FIXED_PRIO_EN for strict lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int PTRW = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_en,
    regfile_wb_arbiter_if.slave req,
    input  logic                alloc_valid,
    input  logic [4:0]          alloc_reg,
    output logic                regWrite,
    output logic [4:0]          WriteRegister,
    output logic [31:0]         WriteData,
    output logic [31:0]         pending
);

    logic [NREQ-1:0] grant;
    logic            xfer;
    int unsigned     pick;
    logic [4:0]      sel_reg;
    logic [31:0]     sel_data;
    logic [31:0]     pend_nxt;

`ifndef WB_FIXED_PRIO_EN
    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] ptr_nxt;
`endif

    // Round-robin done as two constant-index passes: first at or above rr_ptr, then from 0.
    always_comb begin
        xfer = 1'b0;
        pick = 0;
        if (!reset && wb_en) begin
`ifndef WB_FIXED_PRIO_EN
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!xfer && req.req_valid[i] && (32'(rr_ptr) <= i)) begin
                    xfer = 1'b1;
                    pick = i;
                end
            end
`endif
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!xfer && req.req_valid[i]) begin
                    xfer = 1'b1;
                    pick = i;
                end
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_reg  = '0;
        sel_data = '0;
`ifndef WB_FIXED_PRIO_EN
        ptr_nxt  = rr_ptr;
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (xfer && (pick == i)) begin
                grant[i] = 1'b1;
                sel_reg  = req.req_reg[5*i +: 5];
                sel_data = req.req_data[32*i +: 32];
`ifndef WB_FIXED_PRIO_EN
                ptr_nxt  = (i == NREQ - 1) ? '0 : PTRW'(i + 1);
`endif
            end
        end
    end

    assign req.req_ready = grant;

`ifndef WB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= ptr_nxt;
        end
    end
`endif

    // Clear first, then set, so a new allocation supersedes a retiring producer.
    always_comb begin
        pend_nxt = pending;
        if (xfer) begin
            pend_nxt[sel_reg] = 1'b0;
        end
        if (alloc_valid && (alloc_reg != '0)) begin
            pend_nxt[alloc_reg] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (xfer) begin
            regWrite      <= (sel_reg != '0);
            WriteRegister <= sel_reg;
            WriteData     <= sel_data;
        end else begin
            regWrite      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int PTRW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic        regWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] pending;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_en         (wb_en),
        .req           (bus),
        .alloc_valid   (alloc_valid),
        .alloc_reg     (alloc_reg),
        .regWrite      (regWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t             exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              ptr = 0;
    logic [31:0]     m_pend = '0;
    bit              held[NREQ];
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] r, input logic [31:0] d);
        bus.req_valid[i]       = v;
        bus.req_reg[5*i +: 5]  = r;
        bus.req_data[32*i +: 32] = d;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
        reset       = 1'b0;
        wb_en       = 1'b1;
        alloc_valid = 1'b0;
        alloc_reg   = 5'd0;
    endtask

    // One cycle: inputs are already driven; check grant, advance the model, check the scoreboard after the edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] er;
        logic [4:0]      r;
        #1;
        g = -1;
        if (!reset && wb_en) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        last_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        if (reset) begin
            ptr    = 0;
            m_pend = '0;
        end else begin
            if (g >= 0) begin
                r = bus.req_reg[5*g +: 5];
                if (r != 5'd0) exp_q.push_back('{r, bus.req_data[32*g +: 32]});
                m_pend[r] = 1'b0;
`ifndef WB_FIXED_PRIO_EN
                ptr = (g + 1) % NREQ;
`endif
            end
            if (alloc_valid && alloc_reg != 5'd0) m_pend[alloc_reg] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) held[i] = bus.req_valid[i] && (g != i);
        @(posedge clk);
        #2;
        chk("pending", pending, m_pend);
    endtask

    task automatic drive_rand();
        for (int i = 0; i < NREQ; i++) begin
            if (!held[i]) set_req(i, $urandom_range(0, 99) < 55, 5'($urandom_range(0, 15)), $urandom);
        end
        wb_en       = $urandom_range(0, 99) < 85;
        reset       = $urandom_range(0, 199) == 0;
        alloc_valid = $urandom_range(0, 99) < 40;
        alloc_reg   = 5'($urandom_range(0, 15));
    endtask

    // Write monitor: every regWrite must match the oldest expected write.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (regWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data %h expected no write at %0t",
                             WriteRegister, WriteData, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("WriteRegister", 32'(WriteRegister), 32'(w.r));
                    chk("WriteData", WriteData, w.d);
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missing_write: got regWrite=0 expected write reg %0d at %0t",
                         exp_q[0].r, $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        logic [NREQ-1:0] fair_exp[6];
        logic [NREQ-1:0] resume_exp;
`ifdef WB_FIXED_PRIO_EN
        fair_exp   = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        resume_exp = 3'b001;
`else
        fair_exp   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        resume_exp = 3'b010;
`endif
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));

        // Reset with every requester asking
        repeat (2) begin
            @(negedge clk);
            step();
        end
        chk("reset_regWrite", 32'(regWrite), 32'd0);
        chk("reset_WriteRegister", 32'(WriteRegister), 32'd0);
        chk("reset_WriteData", WriteData, 32'd0);

        // Fairness with all three continuously valid
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            reset = 1'b0;
            step();
            chk("fair_grant", 32'(last_ready), 32'(fair_exp[c]));
        end

        // Single write from requester 1
        @(negedge clk);
        clear_inputs();
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        chk("single_ready", 32'(last_ready), 32'b010);
        chk("single_regWrite", 32'(regWrite), 32'd1);
        chk("single_WriteRegister", 32'(WriteRegister), 32'd5);
        chk("single_WriteData", WriteData, 32'hDEADBEEF);

        // Write to r0 is consumed but never reaches the file
        @(negedge clk);
        clear_inputs();
        set_req(2, 1'b1, 5'd0, 32'h1234);
        step();
        chk("r0_ready", 32'(last_ready), 32'b100);
        chk("r0_regWrite", 32'(regWrite), 32'd0);
        chk("r0_pending0", 32'(pending[0]), 32'd0);

        // Scoreboard set/clear races
        @(negedge clk);
        clear_inputs();
        alloc_valid = 1'b1;
        alloc_reg   = 5'd7;
        step();
        chk("race_alloc7", 32'(pending[7]), 32'd1);
        @(negedge clk);
        clear_inputs();
        set_req(0, 1'b1, 5'd7, 32'hA5A5_0007);
        alloc_valid = 1'b1;
        alloc_reg   = 5'd7;
        step();
        chk("race_same_reg", 32'(pending[7]), 32'd1);
        @(negedge clk);
        clear_inputs();
        set_req(0, 1'b1, 5'd7, 32'h5A5A_0007);
        alloc_valid = 1'b1;
        alloc_reg   = 5'd9;
        step();
        chk("race_diff_clear7", 32'(pending[7]), 32'd0);
        chk("race_diff_set9", 32'(pending[9]), 32'd1);

        // Freeze, then resume from the held pointer
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), 32'hF00 + 32'(i));
        wb_en = 1'b0;
        step();
        repeat (2) begin
            @(negedge clk);
            step();
            chk("freeze_regWrite", 32'(regWrite), 32'd0);
        end
        chk("freeze_ready", 32'(last_ready), 32'd0);
        @(negedge clk);
        wb_en = 1'b1;
        step();
        chk("resume_grant", 32'(last_ready), 32'(resume_exp));

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            drive_rand();
            step();
        end

        @(negedge clk);
        clear_inputs();
        step();
        @(negedge clk);
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
